// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter through a tx_en/tx_data/tx_ready handshake.
// tx_data is registered and only changes on a launch, so it is stable for the whole frame.
module uart_tx_fifo #(
  parameter int ELEMENT_WIDTH = 8,
  parameter int DEPTH         = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [ELEMENT_WIDTH-1:0]   wr_data,
  input  logic                       flush,
  input  logic                       clear_overflow,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow,
  output logic                       busy,
  output logic                       tx_en,
  output logic [ELEMENT_WIDTH-1:0]   tx_data,
  input  logic                       tx_ready
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  typedef enum logic [1:0] {D_IDLE, D_SEND, D_WAIT} state_e;

  logic [ELEMENT_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]            level_q, level_d;
  logic                     overflow_q, overflow_d;
  logic                     tx_en_q, tx_en_d;
  logic [ELEMENT_WIDTH-1:0] tx_data_q, tx_data_d;
  state_e                   state_q, state_d;
  logic                     wr_acc, pop;

  assign full     = (level_q == FULL_LVL);
  assign empty    = (level_q == '0);
  assign level    = level_q;
  assign overflow = overflow_q;
  assign tx_en    = tx_en_q;
  assign tx_data  = tx_data_q;
  assign busy     = !empty || (state_q != D_IDLE);

  // Writes are judged against the registered full flag: no write-through on a same-cycle pop.
  assign wr_acc = wr_en && !full && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= D_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      D_IDLE:  if (pop) state_d = D_SEND;
      D_SEND:  state_d = D_WAIT;
      D_WAIT:  if (tx_ready) state_d = D_IDLE;
      default: state_d = D_IDLE;
    endcase
  end

  always_comb begin
    pop     = (state_q == D_IDLE) && tx_ready && !empty && !flush;
    tx_en_d = pop;
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;
    tx_data_d  = tx_data_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
    if (flush) begin
      rd_ptr_d = wr_ptr_q;
      level_d  = '0;
    end else begin
      if (pop) begin
        rd_ptr_d  = rd_ptr_q + 1'b1;
        tx_data_d = mem_q[rd_ptr_q];
      end
      case ({wr_acc, pop})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end
    if (clear_overflow) overflow_d = 1'b0;
    // A dropped write outranks a same-cycle clear.
    if (wr_en && full && !flush) overflow_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      tx_en_q    <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      tx_en_q    <= tx_en_d;
      tx_data_q  <= tx_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a behavioural UART transmitter and a byte scoreboard.
module tb_uart_tx_fifo;
  localparam int BITC = 4;

  logic       clk = 1'b0, rst = 1'b1;
  logic       wr_en = 1'b0, flush = 1'b0, clear_overflow = 1'b0, stall = 1'b0;
  logic [7:0] wr_data = '0;
  logic       full, empty, overflow, busy, tx_en, tx_ready;
  logic [4:0] level;
  logic [7:0] tx_data;

  int         n_assert = 0, n_fail = 0;
  logic [7:0] sb[$];

  logic       tx_busy, prev_en;
  int         cyc_n;
  logic [7:0] fbyte;
  logic [9:0] line_q, last_line;

  uart_tx_fifo #(.ELEMENT_WIDTH(8), .DEPTH(16)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .flush(flush),
    .clear_overflow(clear_overflow), .full(full), .empty(empty), .level(level),
    .overflow(overflow), .busy(busy), .tx_en(tx_en), .tx_data(tx_data), .tx_ready(tx_ready)
  );

  always #5 clk = ~clk;

  assign tx_ready = !tx_busy && !stall;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Transmitter: one frame is start + 8 data (LSB first) + stop, BITC cycles per bit.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_busy <= 1'b0;
      cyc_n   <= 0;
    end else if (!tx_busy) begin
      if (tx_en) begin
        tx_busy <= 1'b1;
        cyc_n   <= 0;
        fbyte   <= tx_data;
      end
    end else begin
      if (cyc_n % BITC == 0) begin
        if (cyc_n == 0)              line_q[0] <= 1'b0;
        else if (cyc_n / BITC == 9)  line_q[9] <= 1'b1;
        else                         line_q[cyc_n / BITC] <= tx_data[cyc_n / BITC - 1];
      end
      if (cyc_n == 10 * BITC - 1) begin
        tx_busy   <= 1'b0;
        last_line <= line_q;
      end
      cyc_n <= cyc_n + 1;
    end
  end

  always @(negedge clk) begin
    if (rst) prev_en = 1'b0;
    else begin
      if (tx_en) begin
        chk("tx_en_gap", prev_en, 0);
        chk("sb_has_entry", sb.size() != 0, 1);
        if (sb.size() != 0) chk("tx_data_order", tx_data, sb.pop_front());
      end
      if (tx_busy) chk("tx_data_stable", tx_data, fbyte);
      prev_en = tx_en;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 3000 && !done; i++) begin
      cyc();
      done = !busy && !tx_busy && (sb.size() == 0);
    end
    chk("drain_timeout", done, 1);
  endtask

  initial begin
    #23 rst = 1'b0;
    cyc();
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_level", level, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tx_en", tx_en, 0);
    chk("rst_tx_data", tx_data, 0);

    // Single byte latency and line pattern
    wr_en = 1'b1; wr_data = 8'hA5; sb.push_back(8'hA5);
    cyc();
    wr_en = 1'b0;
    chk("single_level_w1", level, 1);
    cyc();
    chk("single_tx_en_w2", tx_en, 1);
    chk("single_level_w2", level, 0);
    chk("single_busy", busy, 1);
    wait_idle();
    chk("single_line", last_line, 10'b1101001010);
    chk("single_busy_fall", busy, 0);

    // Burst to full, then drain in order
    stall = 1'b1;
    wr_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wr_data = 8'(i); sb.push_back(8'(i));
      cyc();
    end
    wr_en = 1'b0;
    chk("burst_full", full, 1);
    chk("burst_level", level, 16);
    stall = 1'b0;
    wait_idle();
    chk("burst_empty", empty, 1);

    // Overflow with stalled transmitter
    stall = 1'b1;
    wr_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wr_data = 8'h40 + 8'(i); sb.push_back(8'h40 + 8'(i));
      cyc();
    end
    wr_data = 8'h77;
    cyc();
    wr_en = 1'b0;
    chk("ovf_set", overflow, 1);
    chk("ovf_level", level, 16);
    clear_overflow = 1'b1;
    cyc();
    clear_overflow = 1'b0;
    chk("ovf_clear", overflow, 0);
    clear_overflow = 1'b1; wr_en = 1'b1; wr_data = 8'h78;
    cyc();
    clear_overflow = 1'b0; wr_en = 1'b0;
    chk("ovf_set_wins", overflow, 1);
    chk("ovf_set_wins_level", level, 16);
    clear_overflow = 1'b1;
    cyc();
    clear_overflow = 1'b0;
    chk("ovf_clear2", overflow, 0);

    // Pop and write in the same cycle while full: write dropped
    stall = 1'b0; wr_en = 1'b1; wr_data = 8'h88;
    cyc();
    wr_en = 1'b0;
    chk("popfull_overflow", overflow, 1);
    chk("popfull_level", level, 15);
    chk("popfull_tx_en", tx_en, 1);
    clear_overflow = 1'b1;
    cyc();
    clear_overflow = 1'b0;
    wait_idle();

    // Pop and write in the same cycle at level 3
    stall = 1'b1;
    wr_en = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      wr_data = 8'hA0 + 8'(i); sb.push_back(8'hA0 + 8'(i));
      cyc();
    end
    chk("lvl3_before", level, 3);
    stall = 1'b0; wr_data = 8'hA4; sb.push_back(8'hA4);
    cyc();
    wr_en = 1'b0;
    chk("lvl3_after", level, 3);
    wait_idle();

    // Flush during the frame of the first byte
    wr_en = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      wr_data = 8'hC0 + 8'(i);
      if (i == 1) sb.push_back(8'hC1);
      cyc();
    end
    wr_en = 1'b0;
    chk("flush_pre_level", level, 4);
    flush = 1'b1; wr_en = 1'b1; wr_data = 8'h99;
    cyc();
    flush = 1'b0; wr_en = 1'b0;
    chk("flush_empty", empty, 1);
    chk("flush_level", level, 0);
    chk("flush_no_ovf", overflow, 0);
    chk("flush_busy_inflight", busy, 1);
    wait_idle();
    repeat (5) cyc();
    chk("flush_still_empty", empty, 1);

    // Asynchronous reset mid-frame
    wr_en = 1'b1; wr_data = 8'h11; sb.push_back(8'h11);
    cyc();
    wr_data = 8'h22;
    cyc();
    wr_en = 1'b0;
    repeat (10) cyc();
    chk("arst_pre_data", tx_data, 8'h11);
    chk("arst_pre_level", level, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_tx_en", tx_en, 0);
    chk("arst_tx_data", tx_data, 0);
    chk("arst_level", level, 0);
    chk("arst_empty", empty, 1);
    chk("arst_busy", busy, 0);
    @(posedge clk);
    #3 rst = 1'b0;
    cyc();
    wr_en = 1'b1; wr_data = 8'h3C; sb.push_back(8'h3C);
    cyc();
    wr_en = 1'b0;
    wait_idle();
    chk("arst_line_3c", last_line, 10'b1001111000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Byte FIFO and dispatcher sitting directly upstream of the UART transmitter. Absorbs bursts of bytes from the command/response logic and feeds them one at a time into the transmitter's `tx_en`/`tx_data`/`tx_ready` handshake. The transmitter's `tx_data` stays stable for the whole frame. Write-side overflow is reported with a sticky flag.

## Interface
- `ELEMENT_WIDTH`, 8, bits per byte/element; must match the transmitter.
- `DEPTH`, 16, FIFO entries; power of two, ≥ 2.
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `wr_en`  in  1  write strobe; one element per cycle.
- `wr_data`  in  ELEMENT_WIDTH  element to enqueue.
- `flush`  in  1  synchronous discard of all queued (not in-flight) elements.
- `clear_overflow`  in  1  synchronous clear of `overflow`.
- `full`  out  1  level == DEPTH.
- `empty`  out  1  level == 0.
- `level`  out  $clog2(DEPTH)+1  number of queued elements.
- `overflow`  out  1  sticky: a write was dropped.
- `busy`  out  1  queue non-empty or dispatcher not in D_IDLE.
- `tx_en`  out  1  one-cycle launch pulse to the transmitter.
- `tx_data`  out  ELEMENT_WIDTH  element being transmitted; held stable until next launch.
- `tx_ready`  in  1  transmitter idle and accepting.

## Operation
- Storage: DEPTH×ELEMENT_WIDTH array, `$clog2(DEPTH)`-bit read/write pointers wrapping modulo DEPTH, registered level counter. `full`/`empty` are derived from the registered level.
- Write accepted iff `wr_en && !full && !flush`. Entry goes to `mem[wr_ptr]`, wr_ptr+1.
- Write with `full`=1 is dropped and `overflow` is set. This applies even if a pop happens in the same cycle; no write-through.
- Pop and accepted write in the same cycle: level unchanged, both pointers advance.
- `flush`: rd_ptr←wr_ptr, level←0. Any write that cycle is discarded without setting `overflow`. A pop that cycle is suppressed. An element already launched is not aborted.
- `clear_overflow` and an overflowing write in the same cycle: `overflow` stays 1 (set wins).
- Dispatcher FSM:
  - D_IDLE: if `tx_ready && !empty && !flush`: `tx_data`←`mem[rd_ptr]`, rd_ptr+1, level−1, `tx_en`←1, go D_SEND.
  - D_SEND: `tx_en`←0, go D_WAIT (unconditional; `tx_ready` is ignored here).
  - D_WAIT: stay until `tx_ready`=1, then go D_IDLE.
- `tx_data` changes only on a pop in D_IDLE. Between launches it holds the last transmitted value, because the transmitter samples it bit by bit.
- `busy` = `!empty || state != D_IDLE`.

## Timing
- Reset (async assert, sync release): `tx_en`=0, `tx_data`=0, `full`=0, `empty`=1, `level`=0, `overflow`=0, `busy`=0, pointers 0, FSM D_IDLE. Queue contents are lost.
- Reset mid-frame: outputs return to reset values immediately. The transmitter shares `rst` and aborts too.
- `tx_en` is registered and high exactly one cycle per element. It is never high in two consecutive cycles.
- Latency, with empty queue, transmitter idle, write at cycle W:
  - level=1 at W+1;
  - pop decision at W+1;
  - `tx_en`=1 and `tx_data` valid at W+2.
- Back-to-back: `tx_ready` rises at cycle R (seen in D_WAIT) → D_IDLE at R+1 → next `tx_en` at R+2.
- Status outputs (`full`, `empty`, `level`, `overflow`) update the cycle after the causing event.
- `level` never exceeds DEPTH and never underflows. Pointer wrap at DEPTH−1→0 is transparent.

## Test plan
- Single byte: reset, write 0xA5 at cycle W with transmitter idle → `tx_en` pulse at W+2, `tx_data`=0xA5 held through stop bit; UART line shows 0,1,0,1,0,0,1,0,1,1 (start, LSB-first, stop); `busy` falls after `tx_ready` returns.
- Burst: write 0x00..0x0F on 16 consecutive cycles → `full`=1 after the last write. All 16 bytes are transmitted in order, exactly one `tx_en` per frame, `tx_data` never changes mid-frame.
- Overflow: fill to DEPTH with transmitter stalled (`tx_ready`=0), write 0x77 → `overflow`=1, `level`=16, 0x77 never sent. Pulse `clear_overflow` → `overflow`=0.
- Simultaneous pop+write at full: `tx_ready` rises while `full`, `wr_en`=1 → write dropped, `overflow`=1, `level`=15. Simultaneous write+pop at level 3 → `level` stays 3.
- Flush: queue 5 bytes, flush during frame of byte 1 → byte 1 completes, bytes 2–5 are never sent, `empty`=1. `wr_en` in the flush cycle → not stored, `overflow` stays 0.
- Async reset mid-frame: assert `rst` between clock edges during a data bit → `tx_en`=0, `tx_data`=0, `level`=0 immediately. After release, a new write of 0x3C transmits correctly.
